mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Combined MEM and MEM/WB pipeline stage for the ARM core.
- Takes the EXE-stage result, runs loads and stores on an external word memory through a req/ack handshake, and freezes the upstream pipeline while an access is outstanding.
- Drives the registered writeback triple (wb_en, wb_dest, wb_value). This triple is the producer end of the writeback interface that the decode stage's register file consumes.

Parameters:
ADDR_BASE, 1024, byte address of data memory word 0; subtracted from alu_result before word indexing
TIMEOUT, 255, max BUSY cycles without mem_ack before abort (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
exe_wb_en  in  1  EXE instruction writes a register
exe_mem_r_en  in  1  EXE instruction is a load
exe_mem_w_en  in  1  EXE instruction is a store
exe_dest  in  4  destination register
alu_result  in  32  ALU result / effective byte address
val_rm  in  32  store data
mem_req  out  1  memory request, held until acknowledged
mem_we  out  1  1 = write, 0 = read
mem_addr  out  32  word address
mem_wdata  out  32  write data
mem_rdata  in  32  read data, valid when mem_ack = 1
mem_ack  in  1  one-cycle completion pulse
freeze  out  1  stall PC, IF/ID and ID/EXE registers
wb_en  out  1  writeback enable to register file
wb_dest  out  4  writeback register index
wb_value  out  32  writeback data
err  out  1  sticky memory-timeout flag

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE.
  - mem_req, mem_we, mem_addr, mem_wdata, wb_en, wb_dest, wb_value, err all 0.
  - Holding register and timeout counter 0.
  - Takes effect mid-access: the transaction is dropped and mem_req falls immediately.
- States: IDLE, BUSY, DONE.
- Memory op: op = exe_mem_r_en | exe_mem_w_en. If both are high, the op is a load and the store is ignored.
- IDLE, op = 0:
  - freeze = 0.
  - Clock edge loads wb_en <= exe_wb_en, wb_dest <= exe_dest, wb_value <= alu_result.
  - Latency 1 cycle.
- IDLE, op = 1:
  - freeze = 1, combinational in the same cycle.
  - Clock edge latches mem_we <= (store and not load), mem_addr <= (alu_result - ADDR_BASE) >> 2 (unsigned, mod 2^32), mem_wdata <= val_rm, and exe_wb_en / exe_dest into hold registers.
  - Same edge sets mem_req <= 1 and goes to BUSY.
  - Writeback register loads a bubble (wb_en <= 0).
- BUSY:
  - freeze = 1. mem_req, mem_we, mem_addr, mem_wdata held stable.
  - Writeback register loads a bubble every cycle.
  - On a cycle with mem_ack = 1: capture mem_rdata into the hold register (loads only), mem_req <= 0, go to DONE.
  - mem_ack in any other state is ignored.
- DONE:
  - freeze = 0.
  - Edge loads wb_en <= hold_wb_en & is_load, wb_dest <= hold_dest, wb_value <= hold_rdata (loads) or 0 (stores).
  - Goes to IDLE; the pipeline advances on the same edge.
  - The next instruction is evaluated in IDLE, so a back-to-back memory op starts one cycle later and is never re-issued.
- Stores never assert wb_en.
- Load latency: op presented at cycle 0, mem_req high from cycle 1, ack at cycle k ≥ 1, wb_en valid from cycle k+2. A zero-wait memory gives a load-to-wb latency of 3.
- Writeback outputs are registered and hold their value when nothing new loads. Each instruction produces at most one wb_en cycle.
- err is 0 unless MEM_TIMEOUT_EN is defined.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit+ counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the counter reaches TIMEOUT: mem_req <= 0, go to DONE with the load's wb_en suppressed to 0, set err <= 1.
  - err stays 1 until reset.
  - An ack in the same cycle as the timeout wins: normal completion, err unchanged.
- Undefined:
  - BUSY waits indefinitely for mem_ack.
  - No counter logic; err is tied 0.

Test Plan:
- ALU op: exe_wb_en = 1, exe_dest = 4'd3, alu_result = 32'h0000_0055, no mem op -> next cycle wb_en = 1, wb_dest = 3, wb_value = 32'h55; freeze stays 0.
- Store: alu_result = 1028, val_rm = 32'hCAFE_0001, exe_mem_w_en = 1, ack after 3 cycles -> mem_addr = 1, mem_we = 1, mem_wdata = 32'hCAFE_0001; freeze high 4 cycles; wb_en never 1.
- Load: alu_result = 1032, exe_dest = 7, ack in the 2nd BUSY cycle with mem_rdata = 32'h1234_5678 -> mem_addr = 2, mem_we = 0; wb_en = 1, wb_dest = 7, wb_value = 32'h1234_5678 exactly one cycle after DONE; freeze low in DONE.
- Back-to-back loads with mem_ack tied high -> each load issues exactly one mem_req; wb writes are distinct and in order; no duplicate wb_en.
- Reset asserted while BUSY -> mem_req, freeze, wb_en drop to 0 asynchronously; after release, state IDLE and a new ALU op writes back normally.
- MEM_TIMEOUT_EN, TIMEOUT = 8, load, mem_ack never asserted -> mem_req drops after 8 BUSY cycles; err = 1 and sticky; wb_en stays 0; the pipeline resumes.

Source files
------------

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// mem_wb_stage : combined MEM + MEM/WB stage with a req/ack data memory port
//                and a registered writeback triple for the register file.
// Optional     : define MEM_TIMEOUT_EN to abort stalled accesses (sticky err).
// Revision     : 1.0
// ============================================================================
module mem_wb_stage #(
  parameter logic [31:0] ADDR_BASE = 32'd1024,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exe_wb_en,
  input  logic        exe_mem_r_en,
  input  logic        exe_mem_w_en,
  input  logic [3:0]  exe_dest,
  input  logic [31:0] alu_result,
  input  logic [31:0] val_rm,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        freeze,
  output logic        wb_en,
  output logic [3:0]  wb_dest,
  output logic [31:0] wb_value,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        wb_en_q, wb_en_d;
  logic [3:0]  wb_dest_q, wb_dest_d;
  logic [31:0] wb_value_q, wb_value_d;
  logic        hold_wb_en_q, hold_wb_en_d;
  logic [3:0]  hold_dest_q, hold_dest_d;
  logic [31:0] hold_rdata_q, hold_rdata_d;
  logic        w_op;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             w_timeout;

  // The Nth BUSY cycle without an ack is the last one allowed.
  assign w_timeout = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign err       = err_q;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
  assign err              = 1'b0;
`endif

  assign w_op = exe_mem_r_en | exe_mem_w_en;

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    wb_en_d      = wb_en_q;
    wb_dest_d    = wb_dest_q;
    wb_value_d   = wb_value_q;
    hold_wb_en_d = hold_wb_en_q;
    hold_dest_d  = hold_dest_q;
    hold_rdata_d = hold_rdata_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (w_op) begin
          state_d      = S_BUSY;
          mem_req_d    = 1'b1;
          mem_we_d     = exe_mem_w_en & ~exe_mem_r_en;
          mem_addr_d   = (alu_result - ADDR_BASE) >> 2;
          mem_wdata_d  = val_rm;
          hold_wb_en_d = exe_wb_en;
          hold_dest_d  = exe_dest;
          hold_rdata_d = 32'd0;
          wb_en_d      = 1'b0;
`ifdef MEM_TIMEOUT_EN
          cnt_d        = '0;
`endif
        end else begin
          wb_en_d    = exe_wb_en;
          wb_dest_d  = exe_dest;
          wb_value_d = alu_result;
        end
      end
      S_BUSY: begin
        wb_en_d = 1'b0;
        if (mem_ack) begin
          if (!mem_we_q) begin
            hold_rdata_d = mem_rdata;
          end
          mem_req_d = 1'b0;
          state_d   = S_DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (w_timeout) begin
          mem_req_d    = 1'b0;
          state_d      = S_DONE;
          hold_wb_en_d = 1'b0;
          err_d        = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_DONE: begin
        // The instruction retires here; the next one is examined back in IDLE.
        wb_en_d    = hold_wb_en_q & ~mem_we_q;
        wb_dest_d  = hold_dest_q;
        wb_value_d = mem_we_q ? 32'd0 : hold_rdata_q;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      wb_en_q      <= 1'b0;
      wb_dest_q    <= 4'd0;
      wb_value_q   <= 32'd0;
      hold_wb_en_q <= 1'b0;
      hold_dest_q  <= 4'd0;
      hold_rdata_q <= 32'd0;
`ifdef MEM_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      wb_en_q      <= wb_en_d;
      wb_dest_q    <= wb_dest_d;
      wb_value_q   <= wb_value_d;
      hold_wb_en_q <= hold_wb_en_d;
      hold_dest_q  <= hold_dest_d;
      hold_rdata_q <= hold_rdata_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  // Gated by reset so a reset mid-access releases the upstream pipeline at once.
  assign freeze    = rst & (((state_q == S_IDLE) & w_op) | (state_q == S_BUSY));
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_en     = wb_en_q;
  assign wb_dest   = wb_dest_q;
  assign wb_value  = wb_value_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// tb_mem_wb_stage : directed scoreboard bench for mem_wb_stage with a small
// word-memory responder and writeback / memory-request monitors.
module tb_mem_wb_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        exe_wb_en, exe_mem_r_en, exe_mem_w_en;
  logic [3:0]  exe_dest;
  logic [31:0] alu_result, val_rm;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        freeze, wb_en, err;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;

  int          checks = 0;
  int          errors = 0;
  logic [35:0] wb_q[$];
  logic [64:0] req_q[$];
  logic [31:0] mem_arr [0:15];
  logic        ack_tie = 1'b0;
  int          ack_after = 0;
  int          frz;

  always #5 clk = ~clk;

  mem_wb_stage #(.ADDR_BASE(32'd1024), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_mem_w_en(exe_mem_w_en),
    .exe_dest(exe_dest), .alu_result(alu_result), .val_rm(val_rm),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .freeze(freeze),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one instruction and hold it until the stage stops freezing.
  task automatic send(input logic wb, input logic rd, input logic wr, input logic [3:0] dest,
                      input logic [31:0] alu, input logic [31:0] rm, output int nfrz);
    logic done;
    exe_wb_en = wb; exe_mem_r_en = rd; exe_mem_w_en = wr;
    exe_dest = dest; alu_result = alu; val_rm = rm;
    nfrz = 0;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!freeze) begin
        done = 1'b1;
        break;
      end
      nfrz++;
    end
    checks++;
    assert (done) else begin
      errors++;
      $error("FAIL send_timeout observed=freeze_stuck expected=release dest=%0d", dest);
    end
    @(posedge clk);
    #1;
    exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; exe_mem_w_en = 1'b0;
    exe_dest = 4'd0; alu_result = 32'd0; val_rm = 32'd0;
  endtask

  // Memory responder: ack in the Nth request cycle, or every cycle when tied.
  initial begin
    int req_cycles;
    req_cycles = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (mem_req) req_cycles++;
      else req_cycles = 0;
      if (ack_tie) mem_ack = 1'b1;
      else mem_ack = mem_req && (ack_after != 0) && (req_cycles == ack_after);
      mem_rdata = (mem_req && !mem_we) ? mem_arr[mem_addr[3:0]] : 32'hDEAD_BEEF;
      if (mem_ack && mem_req && mem_we) mem_arr[mem_addr[3:0]] = mem_wdata;
    end
  end

  // Writeback monitor: every wb_en cycle must match the next expected write.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && wb_en) begin
        checks++;
        assert (wb_q.size() != 0) else begin
          errors++;
          $error("FAIL wb_unexpected observed dest=%0d value=%h expected no write", wb_dest, wb_value);
        end
        if (wb_q.size() != 0) begin
          logic [35:0] e;
          e = wb_q.pop_front();
          chk("wb_dest", 32'(wb_dest), 32'(e[35:32]));
          chk("wb_value", wb_value, e[31:0]);
        end
      end
    end
  end

  // Request monitor: each rising mem_req is one expected access; held fields stay put.
  initial begin
    logic        req_prev;
    logic [64:0] cur;
    req_prev = 1'b0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (mem_req && !req_prev) begin
        checks++;
        assert (req_q.size() != 0) else begin
          errors++;
          $error("FAIL req_unexpected observed addr=%h we=%b expected no request", mem_addr, mem_we);
        end
        if (req_q.size() != 0) begin
          cur = req_q.pop_front();
          chk("req_we", 32'(mem_we), 32'(cur[64]));
          chk("req_addr", mem_addr, cur[63:32]);
          chk("req_wdata", mem_wdata, cur[31:0]);
        end
      end else if (mem_req) begin
        chk("req_stable", {mem_we, mem_addr[30:0]}, {cur[64], cur[62:32]});
      end
      req_prev = mem_req;
    end
  end

  initial begin
    rst = 1'b0;
    exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; exe_mem_w_en = 1'b0;
    exe_dest = 4'd0; alu_result = 32'd0; val_rm = 32'd0;
    for (int i = 0; i < 16; i++) mem_arr[i] = 32'd0;
    mem_arr[2] = 32'h1234_5678;
    mem_arr[4] = 32'hA0A0_0004;
    mem_arr[5] = 32'hB0B0_0005;

    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_wb_dest", 32'(wb_dest), 32'd0);
    chk("rst_wb_value", wb_value, 32'd0);
    chk("rst_freeze", 32'(freeze), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Plain ALU result, then a non-writing ALU op.
    wb_q.push_back({4'd3, 32'h0000_0055});
    send(1'b1, 1'b0, 1'b0, 4'd3, 32'h0000_0055, 32'd0, frz);
    chk("alu_freeze_cycles", 32'(frz), 32'd0);
    chk("alu_wb_en_now", 32'(wb_en), 32'd1);
    send(1'b0, 1'b0, 1'b0, 4'd5, 32'h0000_0099, 32'd0, frz);

    // Store, acked in the third BUSY cycle; exe_wb_en is set but must not write back.
    ack_after = 3;
    req_q.push_back({1'b1, 32'd1, 32'hCAFE_0001});
    send(1'b1, 1'b0, 1'b1, 4'd9, 32'd1028, 32'hCAFE_0001, frz);
    chk("store_freeze_cycles", 32'(frz), 32'd4);
    chk("store_no_wb", 32'(wb_en), 32'd0);

    // Load, acked in the second BUSY cycle; write back one cycle after DONE.
    ack_after = 2;
    req_q.push_back({1'b0, 32'd2, 32'd0});
    wb_q.push_back({4'd7, 32'h1234_5678});
    send(1'b1, 1'b1, 1'b0, 4'd7, 32'd1032, 32'd0, frz);
    chk("load_freeze_cycles", 32'(frz), 32'd3);
    chk("load_wb_timing", 32'(wb_en), 32'd1);

    // Both enables high is a load; reads back the earlier store.
    ack_after = 1;
    req_q.push_back({1'b0, 32'd1, 32'hFFFF_FFFF});
    wb_q.push_back({4'd4, 32'hCAFE_0001});
    send(1'b1, 1'b1, 1'b1, 4'd4, 32'd1028, 32'hFFFF_FFFF, frz);
    chk("rw_load_freeze_cycles", 32'(frz), 32'd2);

    // Back-to-back accesses with mem_ack tied high, including an address below base.
    ack_tie = 1'b1;
    req_q.push_back({1'b0, 32'd4, 32'd0});
    wb_q.push_back({4'd1, 32'hA0A0_0004});
    send(1'b1, 1'b1, 1'b0, 4'd1, 32'd1040, 32'd0, frz);
    chk("b2b_load1_freeze", 32'(frz), 32'd2);
    req_q.push_back({1'b0, 32'd5, 32'd0});
    wb_q.push_back({4'd2, 32'hB0B0_0005});
    send(1'b1, 1'b1, 1'b0, 4'd2, 32'd1044, 32'd0, frz);
    chk("b2b_load2_freeze", 32'(frz), 32'd2);
    req_q.push_back({1'b1, 32'h3FFF_FF00, 32'h0BAD_F00D});
    send(1'b0, 1'b0, 1'b1, 4'd0, 32'd0, 32'h0BAD_F00D, frz);
    ack_tie = 1'b0;

    // Reset in the middle of a stalled load.
    ack_after = 0;
    req_q.push_back({1'b0, 32'd3, 32'd0});
    exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; exe_dest = 4'd6; alu_result = 32'd1036;
    repeat (3) @(negedge clk);
    chk("busy_before_rst", 32'(mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_busy_mem_req", 32'(mem_req), 32'd0);
    chk("rst_busy_freeze", 32'(freeze), 32'd0);
    chk("rst_busy_wb_en", 32'(wb_en), 32'd0);
    exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; exe_dest = 4'd0; alu_result = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    wb_q.push_back({4'd11, 32'h0000_1357});
    send(1'b1, 1'b0, 1'b0, 4'd11, 32'h0000_1357, 32'd0, frz);
    chk("post_rst_freeze", 32'(frz), 32'd0);

`ifdef MEM_TIMEOUT_EN
    // Load with no ack: aborts after TIMEOUT BUSY cycles, no writeback, err sticks.
    req_q.push_back({1'b0, 32'd3, 32'd0});
    send(1'b1, 1'b1, 1'b0, 4'd8, 32'd1036, 32'd0, frz);
    chk("timeout_freeze_cycles", 32'(frz), 32'd9);
    chk("timeout_err", 32'(err), 32'd1);
    wb_q.push_back({4'd12, 32'h0000_2468});
    send(1'b1, 1'b0, 1'b0, 4'd12, 32'h0000_2468, 32'd0, frz);
    chk("timeout_err_sticky", 32'(err), 32'd1);
`else
    chk("err_tied_low", 32'(err), 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk("wb_queue_empty", 32'(wb_q.size()), 32'd0);
    chk("req_queue_empty", 32'(req_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
